// File: rtl/chunked_add_sub.sv
// Multi-cycle WIDTH-bit add/subtract, CHUNK bits per cycle with a registered ripple carry.
// Latency WIDTH/CHUNK cycles from accept to out_valid; one op in flight, so throughput is one per N+2 cycles.
// Backpressure: the result and all flags are held in DONE until out_ready; in_ready is low outside IDLE.
module chunked_add_sub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    localparam int N    = WIDTH / CHUNK;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam int OFFW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  res_q;
    logic [WIDTH-1:0]  res_d;
    logic [WIDTH-1:0]  sum_q;
    logic [IDXW-1:0]   idx_q;
    logic              cy_q;
    logic              carry_q;
    logic              ovf_q;
    logic              zero_q;

    logic [OFFW-1:0]   off;
    logic [CHUNK:0]    csum;
    logic              last_chunk;

    // One chunk slice of the adder; res_d is the partial result with this chunk merged in,
    // so the final chunk can be folded straight into the output registers.
    always_comb begin
        off        = OFFW'(idx_q * CHUNK);
        csum       = {1'b0, a_q[off +: CHUNK]} + {1'b0, b_q[off +: CHUNK]} + {{CHUNK{1'b0}}, cy_q};
        res_d      = res_q;
        res_d[off +: CHUNK] = csum[CHUNK-1:0];
        last_chunk = (idx_q == IDXW'(N - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            cy_q    <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        // Subtraction is a + ~b + ~cin, so the borrow-in inverts too.
                        a_q     <= a;
                        b_q     <= mode ? ~b : b;
                        cy_q    <= mode ? ~cin : cin;
                        idx_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    res_q <= res_d;
                    cy_q  <= csum[CHUNK];
                    if (last_chunk) begin
                        sum_q   <= res_d;
                        carry_q <= csum[CHUNK];
                        ovf_q   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_d[WIDTH-1] != a_q[WIDTH-1]);
                        zero_q  <= ~|res_d;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign carry     = carry_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;

endmodule
